// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite bus encodings shared across the SDRAM controller.
package ahb3lite_pkg;

    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

endpackage

// File: rtl/ahb3lite_sdram_ctrl_pkg.sv
// Types and helpers shared by the SDRAM controller blocks (write buffer FSM,
// byte-enable decode, line geometry).
package ahb3lite_sdram_ctrl_pkg;

    import ahb3lite_pkg::*;

    typedef enum logic [1:0] {
        WBUF_IDLE = 2'd0,
        WBUF_FILL = 2'd1,
        WBUF_REQ  = 2'd2,
        WBUF_DATA = 2'd3
    } wbuf_state_t;

    // log2 of the line size in bytes (burst words * bytes per word)
    function automatic int wbuf_line_lsb(input int burst_size, input int hdata_size);
        return $clog2(burst_size * hdata_size / 8);
    endfunction

    localparam int WBUF_LINE_LSB = wbuf_line_lsb(8, 32);

    // Little-endian byte enables for an access of size hsize at byte offset addr_lsbs.
    function automatic logic [7:0] hsize2be(input logic [2:0] hsize, input logic [2:0] addr_lsbs);
        logic [7:0] mask;
        case (hsize)
            HSIZE_B8:  mask = 8'h01;
            HSIZE_B16: mask = 8'h03;
            HSIZE_B32: mask = 8'h0f;
            default:   mask = 8'hff;
        endcase
        return mask << addr_lsbs;
    endfunction

endpackage

// File: rtl/ahb3lite_sdram_wbuf_if.sv
// Signal bundle between the write buffer, the AHB front-end and the SDRAM scheduler.
interface ahb3lite_sdram_wbuf_if
    import ahb3lite_sdram_ctrl_pkg::*;
#(
    parameter int HADDR_SIZE   = 20,
    parameter int HDATA_SIZE   = 32,
    parameter int TIMEOUT_SIZE = 8
);
    // Handshakes: wr_req_i and its address/size/data stay stable until the cycle
    // wr_ack_o is high (transfer on that edge); sdr_req_o and sdr_addr_o stay stable
    // until sdr_ack_i; each cycle with sdr_rdy_i high consumes the presented word.
    logic                      wr_req_i;
    logic [HADDR_SIZE-1:0]     wr_addr_i;
    logic [2:0]                wr_size_i;
    logic [HDATA_SIZE-1:0]     wr_data_i;
    logic                      wr_ack_o;
    logic                      rd_req_i;
    logic [HADDR_SIZE-1:0]     rd_addr_i;
    logic                      rd_hold_o;
    logic                      flush_i;
    logic [TIMEOUT_SIZE-1:0]   timeout_i;
    logic                      sdr_req_o;
    logic                      sdr_ack_i;
    logic [HADDR_SIZE-1:0]     sdr_addr_o;
    logic                      sdr_rdy_i;
    logic [HDATA_SIZE-1:0]     sdr_data_o;
    logic [HDATA_SIZE/8-1:0]   sdr_dm_o;
    logic                      sdr_last_o;
    logic                      empty_o;
    wbuf_state_t               dbg_state_o;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_size_i, wr_data_i, rd_req_i, rd_addr_i,
               flush_i, timeout_i, sdr_ack_i, sdr_rdy_i,
        output wr_ack_o, rd_hold_o, sdr_req_o, sdr_addr_o, sdr_data_o, sdr_dm_o,
               sdr_last_o, empty_o, dbg_state_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_size_i, wr_data_i, rd_req_i, rd_addr_i,
               flush_i, timeout_i, sdr_ack_i, sdr_rdy_i,
        input  wr_ack_o, rd_hold_o, sdr_req_o, sdr_addr_o, sdr_data_o, sdr_dm_o,
               sdr_last_o, empty_o, dbg_state_o
    );

endinterface

// File: rtl/ahb3lite_sdram_wbuf_mem.sv
// Line data storage: one word per burst beat, per-byte write enables, async read.
module ahb3lite_sdram_wbuf_mem #(
    parameter int  HDATA_SIZE = 32,
    parameter int  BURST_SIZE = 8,
    localparam int NB         = HDATA_SIZE / 8,
    localparam int PTR_W      = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1
) (
    input  logic                  clk,
    input  logic [NB-1:0]         we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [HDATA_SIZE-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [HDATA_SIZE-1:0] rdata_o
);

    // No reset: validity is tracked by the byte enables in the parent.
    logic [HDATA_SIZE-1:0] mem_q [BURST_SIZE];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb3lite_sdram_wbuf.sv
// Write-combining buffer: merges AHB writes into one SDRAM line and drains it
// to the command scheduler as a single masked burst write.
module ahb3lite_sdram_wbuf
    import ahb3lite_sdram_ctrl_pkg::*;
#(
    parameter int HADDR_SIZE   = 20,
    parameter int HDATA_SIZE   = 32,
    parameter int BURST_SIZE   = 8,
    parameter int TIMEOUT_SIZE = 8
) (
    input logic                   PRESETn,
    input logic                   HCLK,
    ahb3lite_sdram_wbuf_if.slave  bus
);

    localparam int NB       = HDATA_SIZE / 8;
    localparam int BOFF_W   = $clog2(NB);
    localparam int LINE_LSB = wbuf_line_lsb(BURST_SIZE, HDATA_SIZE);
    localparam int PTR_W    = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
    localparam int BE_W     = BURST_SIZE * NB;

    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(BURST_SIZE - 1);
    localparam logic [HADDR_SIZE-1:0] LINE_MASK =
        ~((HADDR_SIZE'(1) << LINE_LSB) - HADDR_SIZE'(1));

    function automatic logic [PTR_W-1:0] word_idx(input logic [HADDR_SIZE-1:0] a);
        logic [HADDR_SIZE-1:0] s;
        s = (a >> BOFF_W) & HADDR_SIZE'(BURST_SIZE - 1);
        return s[PTR_W-1:0];
    endfunction

    wbuf_state_t             state_q, state_d;
    logic [HADDR_SIZE-1:0]   base_q, base_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [TIMEOUT_SIZE-1:0] cnt_q, cnt_d;

    logic                  wr_ack;
    logic [NB-1:0]         mem_we;
    logic [NB-1:0]         wr_be;
    logic [NB-1:0]         cur_be;
    logic [PTR_W-1:0]      wr_idx;
    logic [HDATA_SIZE-1:0] mem_rdata;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  line_full;
    logic                  timeout_hit;

    assign wr_be       = NB'(hsize2be(bus.wr_size_i, 3'(bus.wr_addr_i[BOFF_W-1:0])));
    assign wr_idx      = word_idx(bus.wr_addr_i);
    assign wr_hit      = (bus.wr_addr_i & LINE_MASK) == base_q;
    assign rd_hit      = (bus.rd_addr_i & LINE_MASK) == base_q;
    assign line_full   = &be_q;
    assign timeout_hit = (bus.timeout_i != '0) && (cnt_q == bus.timeout_i);
    assign cur_be      = be_q[ptr_q*NB +: NB];

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        be_d    = be_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_ack  = 1'b0;
        mem_we  = '0;

        case (state_q)
            WBUF_IDLE: begin
                cnt_d = '0;
                ptr_d = '0;
                if (bus.wr_req_i) begin
                    wr_ack                   = 1'b1;
                    mem_we                   = wr_be;
                    base_d                   = bus.wr_addr_i & LINE_MASK;
                    be_d[wr_idx*NB +: NB]    = be_q[wr_idx*NB +: NB] | wr_be;
                    state_d                  = WBUF_FILL;
                end
            end

            WBUF_FILL: begin
                // A same-line write always wins; any pending trigger is taken after it.
                if (bus.wr_req_i && wr_hit) begin
                    wr_ack                = 1'b1;
                    mem_we                = wr_be;
                    be_d[wr_idx*NB +: NB] = be_q[wr_idx*NB +: NB] | wr_be;
                    cnt_d                 = '0;
                    if (bus.flush_i || (bus.rd_req_i && rd_hit)) begin
                        state_d = WBUF_REQ;
                    end
                end else if (bus.wr_req_i || line_full || bus.flush_i ||
                             (bus.rd_req_i && rd_hit) || timeout_hit) begin
                    state_d = WBUF_REQ;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WBUF_REQ: begin
                if (bus.sdr_ack_i) begin
                    ptr_d   = '0;
                    state_d = WBUF_DATA;
                end
            end

            WBUF_DATA: begin
                if (bus.sdr_rdy_i) begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        be_d    = '0;
                        state_d = WBUF_IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            default: state_d = WBUF_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q <= WBUF_IDLE;
            base_q  <= '0;
            be_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            be_q    <= be_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    ahb3lite_sdram_wbuf_mem #(
        .HDATA_SIZE (HDATA_SIZE),
        .BURST_SIZE (BURST_SIZE)
    ) u_mem (
        .clk     (HCLK),
        .we_i    (mem_we),
        .waddr_i (wr_idx),
        .wdata_i (bus.wr_data_i),
        .raddr_i (ptr_q),
        .rdata_o (mem_rdata)
    );

    // Data/mask are forced to idle values outside DATA so reset never exposes stale RAM.
    assign bus.wr_ack_o    = wr_ack;
    assign bus.rd_hold_o   = bus.rd_req_i &&
                             (((state_q == WBUF_FILL) && rd_hit) ||
                              (state_q == WBUF_REQ) || (state_q == WBUF_DATA));
    assign bus.sdr_req_o   = (state_q == WBUF_REQ);
    assign bus.sdr_addr_o  = base_q;
    assign bus.sdr_data_o  = (state_q == WBUF_DATA) ? mem_rdata : '0;
    assign bus.sdr_dm_o    = (state_q == WBUF_DATA) ? ~cur_be : '1;
    assign bus.sdr_last_o  = (state_q == WBUF_DATA) && (ptr_q == PTR_LAST);
    assign bus.empty_o     = (state_q == WBUF_IDLE);
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb3lite_sdram_wbuf.sv
// Bench for the SDRAM write-combining buffer: byte-level line model feeding an
// expected-burst scoreboard, a randomised scheduler responder, directed scenarios.
module tb_ahb3lite_sdram_wbuf;

    import ahb3lite_pkg::*;

    localparam int HADDR_SIZE   = 20;
    localparam int HDATA_SIZE   = 32;
    localparam int BURST_SIZE   = 8;
    localparam int TIMEOUT_SIZE = 8;
    localparam int NB           = HDATA_SIZE / 8;
    localparam int LB           = BURST_SIZE * NB;

    // clock / reset
    logic HCLK    = 1'b0;
    logic PRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb3lite_sdram_wbuf_if #(
        .HADDR_SIZE   (HADDR_SIZE),
        .HDATA_SIZE   (HDATA_SIZE),
        .TIMEOUT_SIZE (TIMEOUT_SIZE)
    ) bus ();

    ahb3lite_sdram_wbuf #(
        .HADDR_SIZE   (HADDR_SIZE),
        .HDATA_SIZE   (HDATA_SIZE),
        .BURST_SIZE   (BURST_SIZE),
        .TIMEOUT_SIZE (TIMEOUT_SIZE)
    ) dut (
        .PRESETn (PRESETn),
        .HCLK    (HCLK),
        .bus     (bus)
    );

    // scoreboard state
    int n_vec = 0;
    int n_err = 0;
    logic [HADDR_SIZE-1:0] exp_addr_q[$];
    logic [HDATA_SIZE-1:0] exp_data_q[$];
    logic [NB-1:0]         exp_dm_q[$];

    // reference line model: one byte per address of the open line
    bit                    m_valid = 1'b0;
    logic [HADDR_SIZE-1:0] m_base  = '0;
    logic [7:0]            m_byte[LB];
    bit                    m_wr[LB];

    int park_at = -1;
    bit parked  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_valid = 1'b0;
        for (int k = 0; k < LB; k++) begin
            m_wr[k]   = 1'b0;
            m_byte[k] = 8'h00;
        end
    endfunction

    function automatic void model_flush();
        logic [HDATA_SIZE-1:0] w;
        logic [NB-1:0]         dm;
        if (!m_valid) return;
        exp_addr_q.push_back(m_base);
        for (int i = 0; i < BURST_SIZE; i++) begin
            for (int j = 0; j < NB; j++) begin
                w[8*j +: 8] = m_byte[i*NB + j];
                dm[j]       = !m_wr[i*NB + j];
            end
            exp_data_q.push_back(w);
            exp_dm_q.push_back(dm);
        end
        model_clear();
    endfunction

    function automatic void model_write(input logic [HADDR_SIZE-1:0] a, input logic [2:0] sz,
                                        input logic [HDATA_SIZE-1:0] d);
        logic [HADDR_SIZE-1:0] base;
        int off;
        bit all;
        base = a & ~HADDR_SIZE'(LB - 1);
        if (m_valid && base != m_base) model_flush();
        if (!m_valid) begin
            m_valid = 1'b1;
            m_base  = base;
        end
        for (int k = 0; k < (1 << sz); k++) begin
            off         = int'(a % LB) + k;
            m_byte[off] = d[8*(off % NB) +: 8];
            m_wr[off]   = 1'b1;
        end
        all = 1'b1;
        for (int k = 0; k < LB; k++) if (!m_wr[k]) all = 1'b0;
        if (all) model_flush();
    endfunction

    // driver tasks
    task automatic do_write(input logic [HADDR_SIZE-1:0] a, input logic [2:0] sz,
                            input logic [HDATA_SIZE-1:0] d, output int waited);
        bit ok;
        model_write(a, sz, d);
        @(negedge HCLK);
        bus.wr_req_i  = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_size_i = sz;
        bus.wr_data_i = d;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 400) begin
            #1;
            if (bus.wr_ack_o) ok = 1'b1;
            else begin
                @(negedge HCLK);
                waited++;
            end
        end
        check("wr_accepted", ok, 1);
        if (ok) @(posedge HCLK);
        @(negedge HCLK);
        bus.wr_req_i = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge HCLK);
        bus.flush_i = 1'b1;
        model_flush();
        @(negedge HCLK);
        bus.flush_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_data_q.size() != 0 || !bus.empty_o) && n < 3000) begin
            @(negedge HCLK);
            #2;
            n++;
        end
        check("drain_complete",
              (exp_addr_q.size() == 0) && (exp_data_q.size() == 0) && bus.empty_o, 1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_wr_ack"},  bus.wr_ack_o, 0);
        check({tag, "_rd_hold"}, bus.rd_hold_o, 0);
        check({tag, "_sdr_req"}, bus.sdr_req_o, 0);
        check({tag, "_sdr_addr"}, bus.sdr_addr_o, 0);
        check({tag, "_sdr_data"}, bus.sdr_data_o, 0);
        check({tag, "_sdr_dm"},  bus.sdr_dm_o, {NB{1'b1}});
        check({tag, "_sdr_last"}, bus.sdr_last_o, 0);
        check({tag, "_empty"},   bus.empty_o, 1);
    endtask

    // scheduler responder + monitor: sole driver of sdr_ack_i/sdr_rdy_i
    initial begin
        int  widx;
        bit  in_data;
        bit  r;
        logic [HDATA_SIZE-1:0] d_e, msk;
        logic [NB-1:0] dm_e;
        widx = 0;
        in_data = 1'b0;
        bus.sdr_ack_i = 1'b0;
        bus.sdr_rdy_i = 1'b0;
        forever begin
            @(negedge HCLK);
            bus.sdr_ack_i = 1'b0;
            bus.sdr_rdy_i = 1'b0;
            if (PRESETn) begin
                in_data = 1'b0;
                widx    = 0;
            end else if (in_data) begin
                if (widx == park_at) parked = 1'b1;
                else begin
                    r = ($urandom_range(0, 3) != 0);
                    bus.sdr_rdy_i = r;
                    #1;
                    if (r) begin
                        if (exp_data_q.size() == 0) begin
                            check("unexpected_word", 1, 0);
                        end else begin
                            d_e  = exp_data_q.pop_front();
                            dm_e = exp_dm_q.pop_front();
                            for (int j = 0; j < NB; j++) msk[8*j +: 8] = dm_e[j] ? 8'h00 : 8'hff;
                            check("sdr_data", bus.sdr_data_o & msk, d_e & msk);
                            check("sdr_dm", bus.sdr_dm_o, dm_e);
                        end
                        check("sdr_last", bus.sdr_last_o, (widx == BURST_SIZE - 1));
                        widx++;
                        if (widx == BURST_SIZE) begin
                            in_data = 1'b0;
                            widx    = 0;
                        end
                    end
                end
            end else if (bus.sdr_req_o) begin
                r = ($urandom_range(0, 2) != 0);
                bus.sdr_ack_i = r;
                #1;
                if (r) begin
                    if (exp_addr_q.size() == 0) check("unexpected_req", 1, 0);
                    else check("sdr_addr", bus.sdr_addr_o, exp_addr_q.pop_front());
                    in_data = 1'b1;
                    widx    = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // main stimulus
    initial begin
        int w, n;
        bit seen;
        logic [2:0] sz;
        logic [HADDR_SIZE-1:0] line, off;

        model_clear();
        bus.wr_req_i  = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_size_i = HSIZE_B8;
        bus.wr_data_i = '0;
        bus.rd_req_i  = 1'b0;
        bus.rd_addr_i = '0;
        bus.flush_i   = 1'b0;
        bus.timeout_i = '0;
        repeat (3) @(negedge HCLK);
        #1;
        reset_checks("rst");
        @(negedge HCLK);
        PRESETn = 1'b0;

        // byte writes then explicit flush
        do_write(20'h100, HSIZE_B8, 32'h0000_0011, w);
        do_write(20'h101, HSIZE_B8, 32'h0000_2200, w);
        do_write(20'h102, HSIZE_B8, 32'h0033_0000, w);
        do_write(20'h103, HSIZE_B8, 32'h4400_0000, w);
        do_flush();
        drain();

        // full line of word writes flushes by itself
        for (int i = 0; i < BURST_SIZE; i++) do_write(20'h200 + 20'(4*i), HSIZE_B32, $urandom, w);
        drain();

        // write to another line stalls until the old line drains
        do_write(20'h300, HSIZE_B32, $urandom, w);
        do_write(20'h400, HSIZE_B16, $urandom, w);
        check("miss_write_stalled", (w >= BURST_SIZE), 1);
        #1;
        check("miss_line_opened", bus.empty_o, 0);
        do_flush();
        drain();

        // idle timeout
        bus.timeout_i = 8'd5;
        do_write(20'h700, HSIZE_B32, $urandom, w);
        model_flush();
        n = 0;
        while (!bus.sdr_req_o && n < 40) begin
            @(negedge HCLK);
            #1;
            n++;
        end
        check("timeout_latency", n, 6);
        drain();
        bus.timeout_i = '0;
        do_write(20'h720, HSIZE_B32, $urandom, w);
        seen = 1'b0;
        repeat (1000) begin
            @(negedge HCLK);
            if (bus.sdr_req_o) seen = 1'b1;
        end
        check("timeout_disabled", seen, 0);
        do_flush();
        drain();

        // read hit holds and flushes, read miss does neither
        do_write(20'h500, HSIZE_B32, $urandom, w);
        @(negedge HCLK);
        bus.rd_req_i  = 1'b1;
        bus.rd_addr_i = 20'h508;
        model_flush();
        #1;
        check("rd_hold_hit", bus.rd_hold_o, 1);
        n = 0;
        while (!bus.empty_o && n < 500) begin
            @(negedge HCLK);
            #1;
            if (!bus.empty_o) check("rd_hold_flushing", bus.rd_hold_o, 1);
            n++;
        end
        check("rd_hold_released", bus.rd_hold_o, 0);
        @(negedge HCLK);
        bus.rd_req_i = 1'b0;
        drain();
        do_write(20'h500, HSIZE_B16, $urandom, w);
        @(negedge HCLK);
        bus.rd_req_i  = 1'b1;
        bus.rd_addr_i = 20'h600;
        repeat (10) begin
            @(negedge HCLK);
            #1;
            check("rd_miss_no_hold", bus.rd_hold_o, 0);
            check("rd_miss_no_flush", bus.sdr_req_o, 0);
        end
        bus.rd_req_i = 1'b0;
        do_flush();
        drain();

        // randomised traffic over three lines
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 9) do_flush();
            else begin
                sz   = 3'($urandom_range(0, 2));
                line = 20'h800 + 20'(LB * $urandom_range(0, 2));
                off  = 20'($urandom_range(0, LB - 1)) & ~20'((1 << sz) - 1);
                do_write(line + off, sz, $urandom, w);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge HCLK);
        end
        do_flush();
        drain();

        // reset in the middle of a burst
        park_at = 3;
        parked  = 1'b0;
        for (int i = 0; i < 4; i++) do_write(20'h100 + 20'(4*i), HSIZE_B32, $urandom, w);
        do_flush();
        n = 0;
        while (!parked && n < 500) begin
            @(negedge HCLK);
            n++;
        end
        check("burst_parked_at_word3", parked, 1);
        @(negedge HCLK);
        PRESETn = 1'b1;
        #1;
        reset_checks("midburst_rst");
        @(negedge HCLK);
        @(negedge HCLK);
        PRESETn = 1'b0;
        park_at = -1;
        parked  = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_dm_q.delete();
        model_clear();
        do_write(20'h100, HSIZE_B32, $urandom, w);
        check("post_reset_ack_immediate", w, 0);
        #1;
        check("post_reset_not_empty", bus.empty_o, 0);
        do_flush();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sdram_wbuf.md
Name: ahb3lite_sdram_wbuf

Overview:
Write-combining buffer between the AHB3-Lite port front-end and the SDRAM command scheduler of the SDRAM controller. It collects AHB writes of any HSIZE into one burst-aligned line with per-byte enables, then hands the line to the scheduler as a single masked SDRAM burst write. A flush is triggered by:
- line complete
- write to another line
- read hit
- idle timeout
- explicit request

Parameters:
HADDR_SIZE, 20, AHB address width
HDATA_SIZE, 32, AHB/SDRAM data width (32 or 64)
BURST_SIZE, 8, words per line = SDRAM burst length (1,2,4,8)
TIMEOUT_SIZE, 8, width of idle-timeout value

Ports:
PRESETn  in  1  reset; asynchronous, active-high (already decided)
HCLK  in  1  clock (already decided)
wr_req_i  in  1  write request from AHB front-end
wr_addr_i  in  HADDR_SIZE  byte address
wr_size_i  in  3  HSIZE encoding (B8/B16/B32/B64)
wr_data_i  in  HDATA_SIZE  write data, AHB byte-lane aligned
wr_ack_o  out  1  write accepted this cycle
rd_req_i  in  1  read pending at front-end
rd_addr_i  in  HADDR_SIZE  read byte address
rd_hold_o  out  1  read must stall (buffer holds or is flushing that line)
flush_i  in  1  force flush (e.g. before refresh or port switch)
timeout_i  in  TIMEOUT_SIZE  idle cycles before auto-flush; 0 = disabled
sdr_req_o  out  1  burst write request to scheduler
sdr_ack_i  in  1  scheduler accepted the request
sdr_addr_o  out  HADDR_SIZE  line base address (low bits zero)
sdr_rdy_i  in  1  scheduler consumes one data word this cycle
sdr_data_o  out  HDATA_SIZE  current word
sdr_dm_o  out  HDATA_SIZE/8  data mask, 1 = byte not written
sdr_last_o  out  1  current word is the last of the burst
empty_o  out  1  no valid line held

Behaviour:
- Line size LB = BURST_SIZE*HDATA_SIZE/8 bytes. A line is identified by wr_addr_i[HADDR_SIZE-1:log2(LB)]. Word index = address bits above the byte offset.
- Byte enables come from size and the low address bits, little-endian. Example: B16 at offset 2 -> 4'b1100. Misaligned sizes are the front-end's responsibility; the buffer uses the bits unmodified.
- States:
  - IDLE: line empty.
  - FILL: line valid, merging writes.
  - REQ: sdr_req_o high, waiting for sdr_ack_i.
  - DATA: streaming words out.
- IDLE: wr_req_i gives wr_ack_o=1 in the same cycle (combinational). The line base, data and enables load on that edge. Go to FILL.
- FILL, same-line write: wr_ack_o=1. Enabled bytes overwrite earlier bytes (last write wins). The idle counter clears.
- FILL, different-line write: wr_ack_o=0; go to REQ. The write is accepted after the flush completes.
- Other FILL -> REQ triggers:
  - every byte enable of the line set (checked the cycle after the completing write)
  - flush_i
  - rd_req_i with rd_addr_i in the buffered line
  - idle counter == timeout_i with timeout_i != 0
- Idle counter: saturating, increments each FILL cycle without an accepted write.
- Same-cycle write and timeout: the write wins and the counter clears. flush_i with a same-line write: the write is accepted, then REQ.
- REQ: sdr_req_o=1 and sdr_addr_o=line base, held stable until sdr_ack_i; then go to DATA.
- DATA: word pointer starts at 0 and advances on sdr_rdy_i.
  - sdr_data_o/sdr_dm_o reflect the pointed word combinationally.
  - sdr_dm_o = ~byte enables. Fully unwritten words are still sent, fully masked.
  - sdr_last_o = pointer==BURST_SIZE-1. Last word consumed -> clear enables, go to IDLE (the next write is accepted the following cycle).
- wr_ack_o=0 in REQ and DATA.
- rd_hold_o = rd_req_i & ((FILL & line hit) | REQ | DATA). Read misses in IDLE/FILL are not held.
- flush_i in IDLE is ignored. empty_o=1 only in IDLE.
- Reset: state IDLE, enables cleared, pointer/counter 0. Outputs: wr_ack_o=0, rd_hold_o=0, sdr_req_o=0, sdr_addr_o=0, sdr_data_o=0, sdr_dm_o=all 1, sdr_last_o=0, empty_o=1.
- Reset mid-burst abandons the line; the scheduler must also be reset.

Decomposition:
- Shared package ahb3lite_sdram_ctrl_pkg gets:
  - wbuf state enum
  - function hsize2be(hsize, addr_lsbs)
  - localparam computing log2(LB)
- HSIZE constants come from ahb3lite_pkg.
- One sub-module, ahb3lite_sdram_wbuf_mem: BURST_SIZE x HDATA_SIZE storage with per-byte write enables and async read port. It maps to LUT-RAM/registers per TECHNOLOGY.

Test Plan:
1. B8 writes 0x11,0x22,0x33,0x44 to 0x100..0x103, then flush_i -> one sdr_req_o with addr 0x100. Word0 data 0x44332211, dm 4'b0000; words1-7 dm 4'b1111; sdr_last_o on word 7.
2. Eight B32 writes 0x200..0x21C -> auto-flush without timeout or flush_i. All dm 0. Data in address order.
3. Write 0x300, then write 0x400 -> second write wr_ack_o=0 until line 0x300 drains. Then it is accepted and line 0x400 opens (empty_o=0).
4. timeout_i=5, single write, no further traffic -> sdr_req_o asserts 6 cycles after the write ack. With timeout_i=0 it never asserts within 1000 cycles.
5. Line 0x500 buffered, rd_req_i at 0x508 -> rd_hold_o=1 until the last word is consumed. rd_req_i at 0x600 -> rd_hold_o=0 and no flush.
6. Assert PRESETn during DATA at word 3 -> next cycle all outputs at reset values, empty_o=1. A write to 0x100 is then accepted normally.
